// File: rtl/twiddle_if.sv
// Handshake bundle between the FFT stage controller / butterfly datapath and
// the twiddle sequencer. The sequencer drives the master side.
interface twiddle_if #(
  parameter int N   = 16,
  parameter int MSB = 16
);
  localparam int AW = $clog2(N / 2);

  // Request side (stage controller and butterfly ready)
  logic                  start;
  logic [AW-1:0]         stage;
  logic                  inverse;
  logic                  ready;

  // Coefficient word side
  logic                  valid;
  logic                  last;
  logic signed [MSB-1:0] c_out;
  logic signed [MSB-1:0] cps_out;
  logic signed [MSB-1:0] cms_out;
  logic [AW-1:0]         k_out;
  logic [AW-1:0]         addr_out;

  // Status
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  start, stage, inverse, ready,
    output valid, last, c_out, cps_out, cms_out, k_out, addr_out,
           busy, done, err
  );

  modport slave (
    output start, stage, inverse, ready,
    input  valid, last, c_out, cps_out, cms_out, k_out, addr_out,
           busy, done, err
  );
endinterface

// File: rtl/twiddle_sequencer.sv
// Twiddle-coefficient sequencer for one radix-2 FFT stage pass.
// Walks the N/2 butterflies of a stage, emitting k = (count << stage) mod N/2
// and the c / c+s / c-s coefficient triple (swapped for inverse mode) through
// a registered valid/ready output slot. Coefficients are Q2.(MSB-2) with
// s = sin(2*pi*k/N) and c = cos(2*pi*k/N), each rounded half away from zero;
// c+s and c-s are the sums of those rounded values.
module twiddle_sequencer #(
  parameter int N   = 16,
  parameter int MSB = 16
) (
  input  logic       clk,
  input  logic       rst,
  twiddle_if.master  bus
);

  localparam int AW = $clog2(N / 2);
  localparam int FB = MSB - 2;  // fractional bits of the coefficient words

  localparam logic [AW-1:0] MAX_STAGE = AW'(AW);        // LOGN-1 == AW
  localparam logic [AW-1:0] LAST_CNT  = AW'(N / 2 - 1);

  // Q2.30 fixed-point constants for the elaboration-time trig evaluation.
  localparam longint ONE_Q30 = 64'sd1 <<< 30;
  localparam longint PI_Q30  = 64'sd3373259426;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // Coefficient ROM generation
  // ---------------------------------------------------------------------------
  // Returns round(cos) or round(sin) of 2*pi*k/N at FB fractional bits for
  // k in [0, N/2). Angles past pi/2 are folded onto [0, pi/2] so the Taylor
  // series stays accurate and rounding is symmetric about zero.
  function automatic longint trig_q(input int k, input bit want_sin);
    int     j;
    bit     neg;
    longint x;
    longint x2;
    longint term;
    longint acc;
    longint r;
    j   = k;
    neg = 1'b0;
    if (2 * k > N / 2) begin
      j   = N / 2 - k;
      neg = !want_sin;
    end
    x    = (PI_Q30 * longint'(2 * j)) / longint'(N);
    x2   = (x * x) >>> 30;
    term = want_sin ? x : ONE_Q30;
    acc  = term;
    for (int n = 1; n < 12; n++) begin
      term = (term * x2) >>> 30;
      if (want_sin) term = -term / longint'((2 * n) * (2 * n + 1));
      else          term = -term / longint'((2 * n - 1) * (2 * n));
      acc = acc + term;
    end
    r = (acc + (64'sd1 <<< (29 - FB))) >>> (30 - FB);
    return neg ? -r : r;
  endfunction

  logic signed [MSB-1:0] rom_c   [N/2];
  logic signed [MSB-1:0] rom_cps [N/2];
  logic signed [MSB-1:0] rom_cms [N/2];

  // NOTE: the ROMs are elaboration-time constants, so they carry no reset;
  // only real state registers below are cleared.
  for (genvar g = 0; g < N / 2; g++) begin : g_rom
    localparam longint C_V = trig_q(g, 1'b0);
    localparam longint S_V = trig_q(g, 1'b1);
    assign rom_c[g]   = MSB'(C_V);
    assign rom_cps[g] = MSB'(C_V + S_V);
    assign rom_cms[g] = MSB'(C_V - S_V);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_e                state_q,   state_d;
  logic [AW-1:0]         count_q,   count_d;
  logic [AW-1:0]         stage_q,   stage_d;
  logic                  inverse_q, inverse_d;
  logic                  valid_q,   valid_d;
  logic                  last_q,    last_d;
  logic signed [MSB-1:0] c_q,       c_d;
  logic signed [MSB-1:0] cps_q,     cps_d;
  logic signed [MSB-1:0] cms_q,     cms_d;
  logic [AW-1:0]         k_q,       k_d;
  logic [AW-1:0]         addr_q,    addr_d;
  logic                  busy_q,    busy_d;
  logic                  done_q,    done_d;
  logic                  err_q,     err_d;

  // Twiddle index of the word the current count would load (wraps mod N/2).
  logic [AW-1:0] k_idx;
  assign k_idx = count_q << stage_q;

  // Register every piece of state; reset clears all outputs and aborts a pass.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      stage_q   <= '0;
      inverse_q <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      c_q       <= '0;
      cps_q     <= '0;
      cms_q     <= '0;
      k_q       <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      stage_q   <= stage_d;
      inverse_q <= inverse_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      c_q       <= c_d;
      cps_q     <= cps_d;
      cms_q     <= cms_d;
      k_q       <= k_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Next-state logic: accept/reject start in IDLE, fill the output slot and
  // retire the pass in RUN.
  // NOTE: every _d gets a default first, so no path through the case can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    stage_d   = stage_q;
    inverse_d = inverse_q;
    valid_d   = valid_q;
    last_d    = last_q;
    c_d       = c_q;
    cps_d     = cps_q;
    cms_d     = cms_q;
    k_d       = k_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.stage <= MAX_STAGE) begin
            stage_d   = bus.stage;
            inverse_d = bus.inverse;
            count_d   = '0;
            busy_d    = 1'b1;
            state_d   = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (valid_q && bus.ready && last_q) begin
          // Final word accepted: close the pass.
          valid_d = 1'b0;
          last_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (!valid_q || bus.ready) begin
          // Slot free and words remain (the last word has not been loaded).
          c_d     = rom_c[k_idx];
          cps_d   = inverse_q ? rom_cms[k_idx] : rom_cps[k_idx];
          cms_d   = inverse_q ? rom_cps[k_idx] : rom_cms[k_idx];
          k_d     = k_idx;
          addr_d  = count_q;
          last_d  = (count_q == LAST_CNT);
          valid_d = 1'b1;
          count_d = count_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.valid    = valid_q;
  assign bus.last     = last_q;
  assign bus.c_out    = c_q;
  assign bus.cps_out  = cps_q;
  assign bus.cms_out  = cms_q;
  assign bus.k_out    = k_q;
  assign bus.addr_out = addr_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;

  // A stalled word must stay frozen until it is accepted.
  a_stall_hold : assert property (
    @(posedge clk) disable iff (rst)
    (valid_q && !bus.ready) |=> (valid_q && $stable(c_q) && $stable(k_q) && $stable(addr_q))
  );

  // The completion pulse only appears once the slot has drained.
  a_done_idle : assert property (
    @(posedge clk) disable iff (rst)
    done_q |-> (!valid_q && !busy_q)
  );

endmodule
